// File: rtl/maxpool_window_loader.sv
// maxpool_window_loader: collects a row-major stream of activation words into
// one flattened InputH x InputW window for the combinational max-pool stage.
//
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   in_data     : activation word (opaque, DATA_WIDTH bits)
//   in_valid    : in_data valid
//   in_last     : final word of a window
//   in_ready    : loader accepts a word this cycle (registered)
//   win_data    : flattened window, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   win_valid   : win_data holds a complete window
//   win_ready   : consumer takes the window
//   frame_err   : sticky framing-error flag
//   err_clr     : synchronous clear for frame_err (a coincident new error wins)
module maxpool_window_loader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned InputH     = 9,
  parameter int unsigned InputW     = 9
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [DATA_WIDTH-1:0]                  in_data,
  input  logic                                   in_valid,
  input  logic                                   in_last,
  output logic                                   in_ready,
  output logic [InputH*InputW*DATA_WIDTH-1:0]    win_data,
  output logic                                   win_valid,
  input  logic                                   win_ready,
  output logic                                   frame_err,
  input  logic                                   err_clr
);

  localparam int unsigned N  = InputH * InputW;
  localparam int unsigned CW = $clog2(N);
  localparam int unsigned WW = N * DATA_WIDTH;

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]    state_q,     state_d;
  logic [CW-1:0] count_q,     count_d;
  logic [WW-1:0] win_data_q,  win_data_d;
  logic          in_ready_q,  in_ready_d;
  logic          frame_err_q, frame_err_d;

  logic          last_slot;
  logic          accept;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      count_q     <= '0;
      win_data_q  <= '0;
      in_ready_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      win_data_q  <= win_data_d;
      in_ready_q  <= in_ready_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state, slot write and framing check
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    win_data_d  = win_data_q;
    frame_err_d = frame_err_q;
    in_ready_d  = 1'b0;
    last_slot   = (count_q == CW'(N - 1));
    accept      = 1'b0;

    // Clear first so that an error detected this cycle overrides it
    if (err_clr) begin
      frame_err_d = 1'b0;
    end

    case (state_q)
      ST_LOAD: begin
        accept = in_valid && in_ready_q;
        if (accept) begin
          if (in_last && !last_slot) begin
            // Early last: drop the partial window and restart
            frame_err_d = 1'b1;
            count_d     = '0;
          end else begin
            for (int unsigned k = 0; k < N; k++) begin
              if (count_q == CW'(k)) begin
                win_data_d[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
              end
            end
            if (last_slot) begin
              // Missing last still completes the window
              if (!in_last) begin
                frame_err_d = 1'b1;
              end
              state_d = ST_HOLD;
              count_d = '0;
            end else begin
              count_d = count_q + CW'(1);
            end
          end
        end
      end
      ST_HOLD: begin
        if (win_ready) begin
          state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase

    // Ready follows the next state, so it never depends on win_ready combinationally
    in_ready_d = (state_d == ST_LOAD);
  end

  assign in_ready  = in_ready_q;
  assign win_data  = win_data_q;
  assign win_valid = (state_q == ST_HOLD);
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_maxpool_window_loader.sv
// Directed bench for maxpool_window_loader: table of window scenarios plus
// hand-written back-pressure, early-last, set-wins and mid-load reset cases.
module tb_maxpool_window_loader;

  localparam int DW = 16;
  localparam int N  = 81;

  logic            clk;
  logic            rst_n;
  logic [DW-1:0]   in_data;
  logic            in_valid;
  logic            in_last;
  logic            in_ready;
  logic [N*DW-1:0] win_data;
  logic            win_valid;
  logic            win_ready;
  logic            frame_err;
  logic            err_clr;

  int checks   = 0;
  int failures = 0;
  logic          wr_idle;
  logic [DW-1:0] exp_win [N];

  typedef struct {
    logic [15:0] base;
    bit          incr;
    int          sp_idx;
    logic [15:0] sp_val;
    int          last_pos;
    bit          bub;
    bit          exp_err;
    logic [15:0] exp_max;
  } vec_t;

  vec_t vecs [4];

  maxpool_window_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .win_data  (win_data),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .frame_err (frame_err),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All words used here are positive FP16, so unsigned order equals value order
  function automatic logic [15:0] pool_max(input logic [N*DW-1:0] w);
    logic [15:0] m;
    m = w[15:0];
    for (int k = 1; k < N; k++) begin
      if (w[k*DW +: DW] > m) m = w[k*DW +: DW];
    end
    return m;
  endfunction

  task automatic fill(input vec_t v);
    for (int k = 0; k < N; k++) begin
      exp_win[k] = v.incr ? v.base + 16'(k) : v.base;
      if (k == v.sp_idx) exp_win[k] = v.sp_val;
    end
  endtask

  // Offer one word; returns #1 after the edge on which it was accepted
  task automatic push(input logic [DW-1:0] d, input logic l, input bit bub);
    if (bub) begin
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(1, 0) == 1) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int t = 0; t < 200; t++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("push_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic stream(input int start_k, input int last_pos, input bit bub);
    for (int k = start_k; k < N; k++) begin
      if (k == N - 1) chk("win_valid_before_last", 32'(win_valid), 32'd0);
      push(exp_win[k], (k == last_pos), bub);
    end
    chk("win_valid_latency", 32'(win_valid), 32'd1);
    chk("in_ready_in_hold", 32'(in_ready), 32'd0);
  endtask

  task automatic check_window(input logic [15:0] exp_max, input bit exp_err);
    int nbad;
    nbad = 0;
    for (int k = 0; k < N; k++) begin
      if (win_data[k*DW +: DW] !== exp_win[k]) nbad++;
    end
    chk("win_slots_bad", 32'(nbad), 32'd0);
    chk("pool_max", 32'(pool_max(win_data)), 32'(exp_max));
    chk("frame_err", 32'(frame_err), 32'(exp_err));
  endtask

  task automatic handshake();
    win_ready = 1'b1;
    @(posedge clk); #1;
    win_ready = wr_idle;
    chk("win_valid_after_hs", 32'(win_valid), 32'd0);
    chk("in_ready_after_hs", 32'(in_ready), 32'd1);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("frame_err_cleared", 32'(frame_err), 32'd0);
  endtask

  initial begin
    logic [N*DW-1:0] saved;
    int bp_bad;

    vecs[0] = '{16'h4000, 1'b0, 40, 16'h4500, 80, 1'b0, 1'b0, 16'h4500};
    vecs[1] = '{16'h3C00, 1'b0,  0, 16'h4800, 80, 1'b1, 1'b0, 16'h4800};
    vecs[2] = '{16'h4400, 1'b0, 80, 16'h3800, -1, 1'b0, 1'b1, 16'h4400};
    vecs[3] = '{16'h1000, 1'b1, -1, 16'h0000, 80, 1'b1, 1'b0, 16'h1050};

    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    win_ready = 1'b0; err_clr = 1'b0; wr_idle = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_win_valid", 32'(win_valid), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_win_data_zero", 32'(win_data == '0), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_release", 32'(in_ready), 32'd1);

    // Table-driven windows, win_ready held high
    win_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fill(vecs[i]);
      stream(0, vecs[i].last_pos, vecs[i].bub);
      check_window(vecs[i].exp_max, vecs[i].exp_err);
      handshake();
      if (vecs[i].exp_err) clear_err();
    end

    // Back-pressure: window held while upstream keeps offering 0x4200
    wr_idle = 1'b0; win_ready = 1'b0;
    fill(vecs[0]);
    stream(0, 80, 1'b0);
    saved = win_data;
    in_valid = 1'b1; in_data = 16'h4200; in_last = 1'b0;
    bp_bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (in_ready !== 1'b0 || win_valid !== 1'b1 || win_data !== saved) bp_bad++;
    end
    chk("backpressure_hold", 32'(bp_bad), 32'd0);
    handshake();
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_first_word", 32'(win_data[15:0]), 32'h4200);
    exp_win[0] = 16'h4200;
    stream(1, 80, 1'b0);
    check_window(16'h4500, 1'b0);
    handshake();

    // Early last on k=10, then a clean window while the flag stays sticky
    for (int k = 0; k < 10; k++) push(16'h5000, 1'b0, 1'b0);
    push(16'h5000, 1'b1, 1'b0);
    chk("early_last_err", 32'(frame_err), 32'd1);
    chk("early_last_no_valid", 32'(win_valid), 32'd0);
    chk("early_last_ready", 32'(in_ready), 32'd1);
    fill(vecs[0]);
    stream(0, 80, 1'b0);
    check_window(16'h4500, 1'b1);
    handshake();
    clear_err();

    // Clear coinciding with a new early-last error: the set wins
    err_clr = 1'b1;
    push(16'h1234, 1'b1, 1'b0);
    err_clr = 1'b0;
    chk("set_wins_over_clr", 32'(frame_err), 32'd1);
    clear_err();

    // Asynchronous reset after 30 words
    fill(vecs[1]);
    for (int k = 0; k < 30; k++) push(exp_win[k], 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_win_data_zero", 32'(win_data == '0), 32'd1);
    chk("midrst_win_valid", 32'(win_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    stream(0, 80, 1'b0);
    check_window(16'h4800, 1'b0);
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/maxpool_window_loader.md
Name: maxpool_window_loader

Overview:
- Upstream feeder for the combinational 9x9 single-channel max-pool stage.
- Accepts a serial stream of 16-bit FP16 activations, one word per handshake, in row-major order.
- Assembles each InputH x InputW window into one flattened register and presents it with a valid/ready handshake.
- Flags framing errors using a per-window last marker.

Parameters:
- DATA_WIDTH, 16, bits per activation word.
- InputH, 9, window rows.
- InputW, 9, window columns.
- Derived: N = InputH*InputW (81). Counter width CW = clog2(N).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  DATA_WIDTH  activation word.
- in_valid  in  1  in_data valid.
- in_last  in  1  marks the final word of a window.
- in_ready  out  1  loader can accept a word.
- win_data  out  N*DATA_WIDTH  flattened window; connects to the pool stage input.
- win_valid  out  1  win_data holds a complete window.
- win_ready  in  1  consumer accepts the window.
- frame_err  out  1  sticky framing-error flag.
- err_clr  in  1  synchronous clear for frame_err.

Behaviour:
- Reset values (asynchronous, on rst_n low): state=LOAD, count=0, win_data=0, win_valid=0, in_ready=0 for the reset cycle, frame_err=0. After reset release, in_ready=1 while in LOAD.
- Word placement: the k-th accepted word of a window (k=0..N-1, k=r*InputW+c) is written to win_data[k*DATA_WIDTH +: DATA_WIDTH]. The first word lands in the LSBs.
- Write style: direct indexed write, not a shift. Untouched slots keep their old value until overwritten.
- State LOAD:
  - in_ready=1; win_valid=0.
  - On in_valid&&in_ready: write the slot, count++.
  - If count==N-1 on the accept: go to HOLD and clear count to 0.
- State HOLD:
  - in_ready=0; win_valid=1; win_data stable.
  - On win_valid&&win_ready: go to LOAD. in_ready rises the next cycle; no combinational ready path.
- Latency: win_valid asserts on the cycle after the N-th accepted word, which is a registered output.
- Throughput: one window per N+1 cycles minimum (N loads + 1 hold cycle with immediate win_ready).
- Framing check, evaluated per accepted word:
  - in_last=1 with count!=N-1 (early last): set frame_err, discard the partial window, count=0, stay in LOAD.
  - count==N-1 with in_last=0 (missing last): set frame_err, but still complete the window and go to HOLD.
  - frame_err stays set until err_clr is sampled high.
  - If err_clr coincides with a new error, the set wins.
- in_valid while in HOLD: ignored; no write, count unchanged. The upstream holds its data per the valid/ready rule.
- win_ready while in LOAD: ignored.
- Reset mid-window: any partial count is discarded and win_data is zeroed. No window is emitted for the partial data.
- Data is opaque: no arithmetic on words, so FP16 encoding is irrelevant here.

Test Plan:
- Basic window: after reset, stream words 0x4000 for k=0..80 except k=40 = 0x4500, with in_last on k=80 and win_ready held 1. Required: win_valid=1 exactly one cycle after the 81st accept; win_data[40*16+:16]=0x4500; all other slots 0x4000; max-pool output = 0x4500; frame_err=0.
- Back-pressure: hold win_ready=0 for 20 cycles after win_valid while in_valid stays 1 with 0x4200. Required: in_ready=0 and win_data unchanged throughout. After win_ready=1, the next window's first word (0x4200) is accepted one cycle after the handshake.
- Bubbles: toggle in_valid randomly, about 50% duty. Required: slot k equals the k-th accepted word; win_valid only after 81 accepts.
- Early last: assert in_last on word k=10. Required: frame_err=1 the next cycle; count restarts; the following clean 81-word window is emitted correctly. err_clr=1 for one cycle then gives frame_err=0.
- Missing last: send 81 words with in_last=0 throughout. Required: window still emitted, and frame_err=1.
- Reset mid-load: deassert rst_n after 30 words. Required: win_data=0, win_valid=0 immediately (async). After release, a full window is emitted only after 81 new words.
